// File: rtl/lsu_unit_if.sv
// rtl/lsu_unit_if.sv - request, response and data-bus signal bundle for lsu_unit
interface lsu_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_r;
    logic        mem_w;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;

    modport slave (
        input  req_valid, mem_r, mem_w, funct3, addr, wdata, resp_ready,
               bus_req_ready, bus_rvalid, bus_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
               bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
    );

    modport master (
        output req_valid, mem_r, mem_w, funct3, addr, wdata, resp_ready,
               bus_req_ready, bus_rvalid, bus_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
               bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - single-outstanding 64-bit load/store unit with lane steering and extension
module lsu_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic       clk,
    input logic       rst_n,
    lsu_unit_if.slave lsu
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [31:0] TLAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        is_load_q, is_load_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [63:0] bus_addr_q, bus_addr_d;
    logic [63:0] bus_wdata_q, bus_wdata_d;
    logic [7:0]  bus_wstrb_q, bus_wstrb_d;

    logic [7:0]  size_strb;
    logic        misaligned;
    logic        illegal;
    logic [63:0] lane;
    logic [63:0] load_ext;

    always_comb begin
        size_strb  = 8'h01;
        misaligned = 1'b0;
        case (lsu.funct3[1:0])
            2'b00: begin size_strb = 8'h01; misaligned = 1'b0;             end
            2'b01: begin size_strb = 8'h03; misaligned = lsu.addr[0];      end
            2'b10: begin size_strb = 8'h0F; misaligned = |lsu.addr[1:0];   end
            2'b11: begin size_strb = 8'hFF; misaligned = |lsu.addr[2:0];   end
            default: ;
        endcase
        illegal = (lsu.mem_r && lsu.mem_w)
               || (lsu.mem_r && lsu.funct3 == 3'b111)
               || (lsu.mem_w && lsu.funct3[2])
               || misaligned;
    end

    // Read data arrives as a full word; bring the addressed byte lane down to bit 0.
    always_comb begin
        lane = lsu.bus_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{56{lane[7]}},  lane[7:0]};
            3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
            3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
            3'b011:  load_ext = lane;
            3'b100:  load_ext = {56'd0, lane[7:0]};
            3'b101:  load_ext = {48'd0, lane[15:0]};
            3'b110:  load_ext = {32'd0, lane[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        off_d           = off_q;
        f3_d            = f3_q;
        is_load_d       = is_load_q;
        tcnt_d          = tcnt_q;
        resp_valid_d    = resp_valid_q;
        resp_err_d      = resp_err_q;
        resp_data_d     = resp_data_q;
        bus_req_valid_d = bus_req_valid_q;
        bus_we_d        = bus_we_q;
        bus_addr_d      = bus_addr_q;
        bus_wdata_d     = bus_wdata_q;
        bus_wstrb_d     = bus_wstrb_q;
        case (state_q)
            IDLE: begin
                if (lsu.req_valid) begin
                    off_d     = lsu.addr[2:0];
                    f3_d      = lsu.funct3;
                    is_load_d = lsu.mem_r;
                    if (!lsu.mem_r && !lsu.mem_w) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = 64'd0;
                    end else if (illegal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 64'd0;
                    end else begin
                        state_d         = REQ;
                        bus_req_valid_d = 1'b1;
                        bus_we_d        = lsu.mem_w;
                        bus_addr_d      = {lsu.addr[63:3], 3'b000};
                        bus_wstrb_d     = lsu.mem_w ? (size_strb << lsu.addr[2:0]) : 8'd0;
                        bus_wdata_d     = lsu.mem_w ? (lsu.wdata << {lsu.addr[2:0], 3'b000}) : 64'd0;
                    end
                end
            end
            REQ: begin
                if (lsu.bus_req_ready) begin
                    bus_req_valid_d = 1'b0;
                    if (is_load_q) begin
                        state_d = WAIT;
                        tcnt_d  = 32'd0;
                    end else begin
                        // Writes are posted: acknowledge as soon as the bus takes them.
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = 64'd0;
                    end
                end
            end
            WAIT: begin
                if (lsu.bus_rvalid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = load_ext;
                end else if (TIMEOUT != 0) begin
                    if (tcnt_q == TLAST) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 64'd0;
                    end else begin
                        tcnt_d = tcnt_q + 32'd1;
                    end
                end
            end
            RESP: begin
                if (lsu.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            off_q           <= 3'd0;
            f3_q            <= 3'd0;
            is_load_q       <= 1'b0;
            tcnt_q          <= 32'd0;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_data_q     <= 64'd0;
            bus_req_valid_q <= 1'b0;
            bus_we_q        <= 1'b0;
            bus_addr_q      <= 64'd0;
            bus_wdata_q     <= 64'd0;
            bus_wstrb_q     <= 8'd0;
        end else begin
            state_q         <= state_d;
            off_q           <= off_d;
            f3_q            <= f3_d;
            is_load_q       <= is_load_d;
            tcnt_q          <= tcnt_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            resp_data_q     <= resp_data_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_we_q        <= bus_we_d;
            bus_addr_q      <= bus_addr_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_wstrb_q     <= bus_wstrb_d;
        end
    end

    assign lsu.req_ready     = (state_q == IDLE);
    assign lsu.resp_valid    = resp_valid_q;
    assign lsu.resp_err      = resp_err_q;
    assign lsu.resp_data     = resp_data_q;
    assign lsu.bus_req_valid = bus_req_valid_q;
    assign lsu.bus_we        = bus_we_q;
    assign lsu.bus_addr      = bus_addr_q;
    assign lsu.bus_wdata     = bus_wdata_q;
    assign lsu.bus_wstrb     = bus_wstrb_q;
endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - randomized and directed self-checking bench for lsu_unit
module tb_lsu_unit;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    lsu_unit_if bus_if();

    lsu_unit #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level expectations for the operation currently in flight.
    logic        mon_en = 1'b0;
    logic        busy = 1'b0;
    logic        req_phase = 1'b0;
    logic        exp_we;
    logic [63:0] exp_addr, exp_wdata, exp_data;
    logic [7:0]  exp_wstrb;
    logic        exp_err;
    logic [63:0] last_addr, last_wdata;
    logic [7:0]  last_wstrb;
    logic        last_we;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("req_ready", bus_if.req_ready, !busy);
            if (req_phase) begin
                check("bus_req_valid", bus_if.bus_req_valid, 1'b1);
                check("bus_we", bus_if.bus_we, exp_we);
                check("bus_addr", bus_if.bus_addr, exp_addr);
                check("bus_wdata", bus_if.bus_wdata, exp_wdata);
                check("bus_wstrb", bus_if.bus_wstrb, exp_wstrb);
            end else begin
                check("bus_req_valid_idle", bus_if.bus_req_valid, 1'b0);
            end
            if (!busy) begin
                check("resp_valid_idle", bus_if.resp_valid, 1'b0);
            end else if (bus_if.resp_valid) begin
                check("resp_data", bus_if.resp_data, exp_data);
                check("resp_err", bus_if.resp_err, exp_err);
            end
        end
    end

    // Derive what the operation must produce from the ISA rules, then drive it.
    // r: bus_req_ready stall cycles, d: WAIT cycles before rvalid, hold: resp_ready stall.
    task automatic do_op(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input int r, input int d, input logic [63:0] rd, input int hold,
                         output logic [63:0] g_data, output logic g_err, output int g_lat);
        int          n, o, strb, exp_lat, k, t0;
        logic        bad, noop, tmo, use_bus;
        logic [63:0] mask, v;
        n    = 1 << f3[1:0];
        o    = int'(a % 8);
        bad  = (mr && mw) || (mr && f3 == 3'd7) || (mw && f3[2]) || ((mr || mw) && (a % n) != 0);
        noop = !mr && !mw;
        use_bus = !bad && !noop;
        tmo  = use_bus && mr && d >= TO;
        mask = (n == 8) ? ~64'd0 : ((64'd1 << (8 * n)) - 64'd1);
        v    = (rd >> (8 * o)) & mask;
        if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
        strb = ((1 << n) - 1) << o;
        exp_we    = mw;
        exp_addr  = a - (a % 8);
        exp_wstrb = mw ? strb[7:0] : 8'd0;
        exp_wdata = mw ? (wd << (8 * o)) : 64'd0;
        exp_err   = bad || tmo;
        exp_data  = (bad || tmo || !mr || noop) ? 64'd0 : v;
        exp_lat   = !use_bus ? 1 : mw ? r + 2 : tmo ? r + TO + 2 : r + d + 3;

        bus_if.req_valid = 1'b1;
        bus_if.mem_r     = mr;
        bus_if.mem_w     = mw;
        bus_if.funct3    = f3;
        bus_if.addr      = a;
        bus_if.wdata     = wd;
        @(posedge clk); #1;
        t0 = cyc;
        busy = 1'b1;
        req_phase = use_bus;
        bus_if.req_valid = 1'b0;
        bus_if.funct3    = 3'($urandom);
        bus_if.addr      = {$urandom, $urandom};
        bus_if.wdata     = {$urandom, $urandom};
        bus_if.mem_r     = 1'($urandom);
        bus_if.mem_w     = 1'($urandom);
        if (use_bus) begin
            repeat (r) begin @(posedge clk); #1; end
            last_addr  = bus_if.bus_addr;
            last_wdata = bus_if.bus_wdata;
            last_wstrb = bus_if.bus_wstrb;
            last_we    = bus_if.bus_we;
            bus_if.bus_req_ready = 1'b1;
            @(posedge clk); #1;
            bus_if.bus_req_ready = 1'b0;
            req_phase = 1'b0;
            if (mr && d < TO) begin
                repeat (d) begin @(posedge clk); #1; end
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = rd;
                @(posedge clk); #1;
                bus_if.bus_rvalid = 1'b0;
                bus_if.bus_rdata  = {$urandom, $urandom};
            end
        end
        k = 0;
        while (!bus_if.resp_valid && k < 40) begin @(posedge clk); #1; k++; end
        g_lat = cyc - t0 + 1;
        check("latency", 64'(g_lat), 64'(exp_lat));
        g_data = bus_if.resp_data;
        g_err  = bus_if.resp_err;
        repeat (hold) begin
            @(posedge clk); #1;
            check("resp_hold_valid", bus_if.resp_valid, 1'b1);
        end
        bus_if.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.resp_ready = 1'b0;
        busy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] gd, a, wd, rd;
        logic        ge, mr, mw;
        logic [2:0]  f3;
        int          gl, sel;

        bus_if.req_valid     = 1'b0;
        bus_if.mem_r         = 1'b0;
        bus_if.mem_w         = 1'b0;
        bus_if.funct3        = 3'd0;
        bus_if.addr          = 64'd0;
        bus_if.wdata         = 64'd0;
        bus_if.resp_ready    = 1'b0;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rvalid    = 1'b0;
        bus_if.bus_rdata     = 64'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", bus_if.resp_valid, 1'b0);
        check("rst_resp_err", bus_if.resp_err, 1'b0);
        check("rst_resp_data", bus_if.resp_data, 64'd0);
        check("rst_bus_req_valid", bus_if.bus_req_valid, 1'b0);
        check("rst_bus_addr", bus_if.bus_addr, 64'd0);
        check("rst_bus_wstrb", bus_if.bus_wstrb, 8'd0);
        check("rst_bus_wdata", bus_if.bus_wdata, 64'd0);
        check("rst_req_ready", bus_if.req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        do_op(1, 0, 3'b011, 64'h80000008, 64'd0, 0, 0, 64'h1122334455667788, 0, gd, ge, gl);
        check("ld_data", gd, 64'h1122334455667788);
        check("ld_err", ge, 1'b0);
        check("ld_bus_addr", last_addr, 64'h80000008);
        check("ld_wstrb", last_wstrb, 8'h00);
        check("ld_lat", 64'(gl), 64'd3);

        do_op(1, 0, 3'b100, 64'h80000003, 64'd0, 0, 1, 64'h0000000080FF0000, 0, gd, ge, gl);
        check("lbu_data", gd, 64'h0000000000000080);
        do_op(1, 0, 3'b000, 64'h80000003, 64'd0, 1, 0, 64'h0000000080FF0000, 1, gd, ge, gl);
        check("lb_data", gd, 64'hFFFFFFFFFFFFFF80);

        do_op(0, 1, 3'b001, 64'h80000006, 64'hABCD, 3, 0, 64'd0, 0, gd, ge, gl);
        check("sh_we", last_we, 1'b1);
        check("sh_wstrb", last_wstrb, 8'hC0);
        check("sh_wdata_hi", last_wdata >> 48, 64'hABCD);
        check("sh_data", gd, 64'd0);
        check("sh_err", ge, 1'b0);
        check("sh_lat", 64'(gl), 64'd5);

        do_op(1, 0, 3'b010, 64'h80000002, 64'd0, 0, 0, 64'd0, 0, gd, ge, gl);
        check("lw_mis_err", ge, 1'b1);
        check("lw_mis_lat", 64'(gl), 64'd1);
        do_op(1, 1, 3'b011, 64'h80000000, 64'd0, 0, 0, 64'd0, 0, gd, ge, gl);
        check("rw_both_err", ge, 1'b1);
        check("rw_both_lat", 64'(gl), 64'd1);

        do_op(1, 0, 3'b011, 64'h80000010, 64'd0, 0, 99, 64'd0, 2, gd, ge, gl);
        check("tmo_err", ge, 1'b1);
        check("tmo_data", gd, 64'd0);
        check("tmo_lat", 64'(gl), 64'd6);

        // Abort a load mid-WAIT, then deliver its read data late.
        exp_we = 1'b0; exp_addr = 64'h80000020; exp_wdata = 64'd0; exp_wstrb = 8'd0;
        exp_data = 64'd0; exp_err = 1'b0;
        bus_if.req_valid = 1'b1; bus_if.mem_r = 1'b1; bus_if.mem_w = 1'b0;
        bus_if.funct3 = 3'b011; bus_if.addr = 64'h80000020;
        @(posedge clk); #1;
        busy = 1'b1; req_phase = 1'b1; bus_if.req_valid = 1'b0;
        bus_if.bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_req_ready = 1'b0; req_phase = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #2;
        check("abort_req_ready", bus_if.req_ready, 1'b1);
        check("abort_resp_valid", bus_if.resp_valid, 1'b0);
        check("abort_bus_req_valid", bus_if.bus_req_valid, 1'b0);
        check("abort_bus_addr", bus_if.bus_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        busy = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 64'hDEADBEEFCAFEF00D;
        @(posedge clk); #1;
        bus_if.bus_rvalid = 1'b0;
        check("stale_resp_valid", bus_if.resp_valid, 1'b0);
        check("stale_bus_req_valid", bus_if.bus_req_valid, 1'b0);
        do_op(1, 0, 3'b110, 64'h80000024, 64'd0, 0, 2, 64'h89ABCDEF00000000, 0, gd, ge, gl);
        check("post_abort_lwu", gd, 64'h0000000089ABCDEF);
        check("post_abort_err", ge, 1'b0);

        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            mr  = (sel <= 3) || (sel == 8);
            mw  = (sel >= 4 && sel <= 8);
            f3  = 3'($urandom_range(0, 7));
            if (mw && !mr && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
            a   = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                case (f3[1:0])
                    2'b01: a[0] = 1'b0;
                    2'b10: a[1:0] = 2'b00;
                    2'b11: a[2:0] = 3'b000;
                    default: ;
                endcase
            end
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            do_op(mr, mw, f3, a, wd, $urandom_range(0, 3), $urandom_range(0, 5), rd,
                  $urandom_range(0, 2), gd, ge, gl);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
